icache_ctrl: RTL
================

// Module: icache_ctrl
// PURPOSE
//   Direct-mapped instruction cache placed directly upstream of InsFetch.
//   - Looks up the fetch PC and returns the whole 128-bit line (imem_in) plus a hit flag (icacheHit).
//   - On a miss, runs a request/ready handshake to main memory, fills the line, then hits on re-lookup.
//   - InsFetch selects the word within the line and holds its PC while o_hit is low.
// PARAMETERS
//   ADDR_W   32   byte-address width
//   LINE_W   128  line width in bits (4 x 32-bit words), fixed
//   INDEX_W  4    index bits (2**INDEX_W lines)
//   CNT_W    16   miss-counter width
// PORTS
//   clk         in   1        clock, rising edge
//   rstn        in   1        reset: asynchronous, active-high
//   i_req       in   1        fetch lookup valid
//   i_addr      in   ADDR_W   fetch PC (byte address)
//   i_flush     in   1        invalidate all lines
//   o_hit       out  1        line for i_addr valid this cycle (to icacheHit)
//   o_line      out  LINE_W   cached line for i_addr index (to imem_in)
//   o_mem_req   out  1        memory read request
//   o_mem_addr  out  ADDR_W   line-aligned miss address, addr[3:0]=0
//   i_mem_ready in   1        memory data valid; completes request
//   i_mem_data  in   LINE_W   refill line
//   o_miss_cnt  out  CNT_W    saturating miss counter
// BEHAVIOUR
//   Address split: offset=[3:0] (ignored here), index=[3+INDEX_W:4], tag=[ADDR_W-1:4+INDEX_W].
//   Reset (async, immediate):
//     - state=IDLE; all valid bits=0.
//     - o_mem_req=0, o_mem_addr=0, o_miss_cnt=0, o_hit=0.
//     - Data/tag arrays are not cleared.
//   Lookup: combinational from i_addr.
//     - o_hit = i_req & state==IDLE & valid[idx] & tag[idx]==tag(i_addr).
//     - o_line = data[idx] always; it is meaningful only when o_hit=1.
//   FSM states IDLE, REQ, FILL:
//     - IDLE: if i_req and not hit, latch the line address and index, o_miss_cnt+=1 (saturates at all-ones), -> REQ.
//     - REQ: o_mem_req=1; o_mem_addr holds the latched address. i_addr changes are ignored.
//       On i_mem_ready: write data/tag to the latched index, valid=~flush_pend, -> FILL.
//     - FILL: one bubble cycle, o_hit=0, clear flush_pend, -> IDLE. The re-lookup hits in the next cycle.
//   Miss latency: miss seen in cycle N, o_mem_req=1 from N+1, ready in cycle M, FILL at M+1, hit at M+2 at the earliest.
//   i_mem_ready outside REQ: ignored. o_mem_req drops in the cycle after ready (registered).
//   Flush:
//     - Clears all valid bits at the next edge in any state; o_hit=0 in the flush cycle.
//     - Flush in REQ sets flush_pend, so the in-flight fill is written invalid.
//     - Flush together with the ready edge is treated the same way (fill written invalid).
//     - Flush together with an IDLE miss: the miss proceeds and flush_pend is set.
//   i_req low in IDLE: no state change, no counting.
//   Eviction: a miss overwrites its index unconditionally; no write-back (read-only cache).
// STRUCTURE
//   Shared package icache_pkg:
//     - state encoding (IDLE=2'd0, REQ=2'd1, FILL=2'd2)
//     - OFFSET_W=4, LINE_W=128
//     - tag/index width functions
//   Sub-module icache_tag_ram: valid/tag/data arrays.
//     - One synchronous write port; async read by index.
//     - Flash-clear of the valid bits.
//   icache_ctrl holds the FSM, miss latch, flush_pend and the counter.
// TESTING
//   1. After reset, req 0x00000040 -> o_hit=0; next cycle o_mem_req=1, o_mem_addr=0x40.
//      Ready after 3 cycles with data 128'h5A -> FILL, then o_hit=1, o_line=128'h5A, o_miss_cnt=1.
//   2. Same index, other tag: req 0x00000140 -> miss, o_mem_addr=0x140, fill 128'h80.
//      Then req 0x40 -> miss again (evicted), o_miss_cnt=3.
//   3. Hit path: repeated req 0x44/0x48/0x4C after fill -> o_hit=1 every cycle, no o_mem_req, counter unchanged.
//   4. Flush in IDLE after fill -> next cycle req 0x40 gives o_hit=0 and a new miss.
//      Flush in REQ -> fill completes, line stays invalid, re-miss for the same address.
//   5. Reset asserted mid-REQ -> o_mem_req=0 and o_miss_cnt=0 immediately (before next edge).
//      After release, req 0x40 misses.
//   6. i_mem_ready pulsed while IDLE with data 128'hFF -> no array write; a later lookup still misses.

Source files
------------

// File: rtl/icache_pkg.sv
// icache_pkg: shared constants, FSM encoding and address-split helpers for the instruction cache.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package icache_pkg;

  localparam int ADDR_W   = 32;
  localparam int LINE_W   = 128;
  localparam int OFFSET_W = 4;
  localparam int INDEX_W  = 4;
  localparam int CNT_W    = 16;

  function automatic int tag_w(input int aw, input int iw);
    return aw - OFFSET_W - iw;
  endfunction

  function automatic int num_lines(input int iw);
    return 1 << iw;
  endfunction

  localparam int TAG_W = tag_w(ADDR_W, INDEX_W);
  localparam int LINES = num_lines(INDEX_W);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_FILL = 2'd2
  } state_e;

  function automatic logic [INDEX_W-1:0] get_index(input logic [ADDR_W-1:0] a);
    return a[OFFSET_W+INDEX_W-1:OFFSET_W];
  endfunction

  function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1:OFFSET_W+INDEX_W];
  endfunction

endpackage

// File: rtl/icache_if.sv
// icache_if: fetch lookup, flush and memory refill signals between InsFetch/memory and the cache.
// Latency: n/a (wires only).
// Backpressure: fetch stalls while o_hit is low; memory completes a request with i_mem_ready.
interface icache_if
  import icache_pkg::*;
  ();
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_flush;
  logic              o_hit;
  logic [LINE_W-1:0] o_line;
  logic              o_mem_req;
  logic [ADDR_W-1:0] o_mem_addr;
  logic              i_mem_ready;
  logic [LINE_W-1:0] i_mem_data;
  logic [CNT_W-1:0]  o_miss_cnt;

  // Fetch/memory side.
  modport master (
    output i_req, i_addr, i_flush, i_mem_ready, i_mem_data,
    input  o_hit, o_line, o_mem_req, o_mem_addr, o_miss_cnt
  );

  // Cache side.
  modport slave (
    input  i_req, i_addr, i_flush, i_mem_ready, i_mem_data,
    output o_hit, o_line, o_mem_req, o_mem_addr, o_miss_cnt
  );
endinterface

// File: rtl/icache_tag_ram.sv
// icache_tag_ram: valid/tag/data arrays, async read by index, one sync write port, flash-clear of valids.
// Latency: read combinational; write visible the cycle after the edge.
// Backpressure: none; write and clear accepted every cycle.
// Ports: clk/rst_i, rd_idx_i -> rd_vld_o/rd_tag_o/rd_data_o; we_i/wr_idx_i/wr_tag_i/wr_data_i/wr_vld_i; clr_i.
module icache_tag_ram
  import icache_pkg::*;
  (
  input  logic               clk,
  input  logic               rst_i,
  input  logic [INDEX_W-1:0] rd_idx_i,
  output logic               rd_vld_o,
  output logic [TAG_W-1:0]   rd_tag_o,
  output logic [LINE_W-1:0]  rd_data_o,
  input  logic               we_i,
  input  logic [INDEX_W-1:0] wr_idx_i,
  input  logic [TAG_W-1:0]   wr_tag_i,
  input  logic [LINE_W-1:0]  wr_data_i,
  input  logic               wr_vld_i,
  input  logic               clr_i
);

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINE_W-1:0] data_q [LINES];

  // A write in the same cycle as a clear wins for its own index; the
  // controller drives wr_vld_i low whenever a clear is involved.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else begin
      if (clr_i) valid_q <= '0;
      if (we_i)  valid_q[wr_idx_i] <= wr_vld_i;
    end
  end

  // Tag/data storage is deliberately not reset; valid bits guard it.
  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_vld_o  = valid_q[rd_idx_i];
  assign rd_tag_o  = tag_q[rd_idx_i];
  assign rd_data_o = data_q[rd_idx_i];

endmodule

// File: rtl/icache_ctrl.sv
// icache_ctrl: direct-mapped instruction cache with single-outstanding miss refill.
// Latency: hit is combinational; miss in cycle N -> mem req N+1 .. ready M -> FILL M+1 -> hit M+2.
// Backpressure: o_hit low stalls fetch; memory holds off refill by keeping i_mem_ready low.
// Ports: clk, rstn (async, active-high), bus (icache_if.slave: lookup, flush, refill, miss counter).
module icache_ctrl
  import icache_pkg::*;
  (
  input  logic     clk,
  input  logic     rstn,
  icache_if.slave  bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] miss_addr_q, miss_addr_d;
  logic              flush_pend_q, flush_pend_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              rd_vld;
  logic [TAG_W-1:0]  rd_tag;
  logic              we;
  logic              hit;

  // Byte offset within the line is resolved by InsFetch, not here.
  logic unused_offset;
  assign unused_offset = ^bus.i_addr[OFFSET_W-1:0];

  icache_tag_ram u_ram (
    .clk       (clk),
    .rst_i     (rstn),
    .rd_idx_i  (get_index(bus.i_addr)),
    .rd_vld_o  (rd_vld),
    .rd_tag_o  (rd_tag),
    .rd_data_o (bus.o_line),
    .we_i      (we),
    .wr_idx_i  (get_index(miss_addr_q)),
    .wr_tag_i  (get_tag(miss_addr_q)),
    .wr_data_i (bus.i_mem_data),
    .wr_vld_i  (~(flush_pend_q | bus.i_flush)),
    .clr_i     (bus.i_flush)
  );

  // A flush cycle never reports a hit, so a lookup under flush is a miss.
  assign hit = bus.i_req && (state_q == ST_IDLE) && rd_vld &&
               (rd_tag == get_tag(bus.i_addr)) && !bus.i_flush;

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q      <= ST_IDLE;
      miss_addr_q  <= '0;
      flush_pend_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      miss_addr_q  <= miss_addr_d;
      flush_pend_q <= flush_pend_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    miss_addr_d  = miss_addr_q;
    flush_pend_d = flush_pend_q;
    cnt_d        = cnt_q;
    we           = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_req && !hit) begin
          miss_addr_d  = {bus.i_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
          cnt_d        = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
          flush_pend_d = bus.i_flush;
          state_d      = ST_REQ;
        end
      end
      ST_REQ: begin
        // Any flush while the refill is outstanding poisons that refill.
        flush_pend_d = flush_pend_q | bus.i_flush;
        if (bus.i_mem_ready) begin
          we      = 1'b1;
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        flush_pend_d = 1'b0;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.o_hit      = hit;
  assign bus.o_mem_req  = (state_q == ST_REQ);
  assign bus.o_mem_addr = miss_addr_q;
  assign bus.o_miss_cnt = cnt_q;

endmodule
